i2s_dac_transmitter: RTL

Serialises processed stereo samples into a standard I2S stream (BCLK, LRCLK, SDATA) that drives the external DAC. It is the outbound counterpart of the I2S input path that feeds the PWM/processing chain. It sits between the audio processing pipeline and the dac_bclk/dac_lrclk/dac_data pins when the processor is not bypassed. The block is I2S master: it generates BCLK and LRCLK from the system clock.

---
 rtl/i2s_pkg.sv | 35 +++
 rtl/i2s_bclk_gen.sv | 69 ++++++
 rtl/i2s_dac_transmitter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// ----------------------------------------------------------------------------
// i2s_pkg
//
// Shared definitions for the I2S transmit path:
//   - I2S_LEFT / I2S_RIGHT : word-select (lrclk) levels for each channel
//   - I2S_DATA_W           : sample width used by stereo_sample_t
//   - stereo_sample_t      : one stereo sample {l, r}
//   - i2s_state_e          : serializer run/idle state
//   - frame_len()          : bclk periods per stereo frame
// ----------------------------------------------------------------------------
package i2s_pkg;

   localparam int unsigned I2S_DATA_W = 24;

   localparam logic I2S_LEFT  = 1'b0;
   localparam logic I2S_RIGHT = 1'b1;

   // The top-level DATA_W must equal I2S_DATA_W, because this struct carries
   // the held sample between the handshake and the shifter.
   typedef struct packed {
      logic [I2S_DATA_W-1:0] l;
      logic [I2S_DATA_W-1:0] r;
   } stereo_sample_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } i2s_state_e;

   // One frame is a left slot followed by a right slot.
   function automatic int unsigned frame_len(input int unsigned slot_w);
      return 2 * slot_w;
   endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// ----------------------------------------------------------------------------
// i2s_bclk_gen
//
// Bit-clock generator for an I2S master. A divider counts 0..BCLK_DIV-1 while
// run is high and toggles bclk at terminal count, so one bclk period is
// 2*BCLK_DIV clk cycles. The tick strobes are high during the clk cycle whose
// closing edge makes bclk rise (rise_tick) or fall (fall_tick), so logic that
// uses them updates on the same edge as the bclk transition.
//
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-high reset
//   run       in  1 = divider runs; 0 = divider and bclk held at 0 next edge
//   bclk      out registered bit clock
//   rise_tick out strobe: bclk goes 0->1 on the next clk edge
//   fall_tick out strobe: bclk goes 1->0 on the next clk edge
// ----------------------------------------------------------------------------
module i2s_bclk_gen #(
   parameter int unsigned BCLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic bclk,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             bclk_q, bclk_d;
   logic             terminal;

   assign terminal  = (div_cnt_q == DIV_LAST);
   assign rise_tick = run && terminal && !bclk_q;
   assign fall_tick = run && terminal &&  bclk_q;
   assign bclk      = bclk_q;

   // NOTE: every signal assigned in an always_comb gets a default on entry, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      div_cnt_d = div_cnt_q;
      bclk_d    = bclk_q;
      if (!run) begin
         div_cnt_d = '0;
         bclk_d    = 1'b0;
      end else if (terminal) begin
         div_cnt_d = '0;
         bclk_d    = !bclk_q;
      end else begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q <= '0;
         bclk_q    <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         bclk_q    <= bclk_d;
      end
   end

endmodule

// File: rtl/i2s_dac_transmitter.sv
// ----------------------------------------------------------------------------
// i2s_dac_transmitter
//
// I2S master transmitter for the external DAC. Accepts one stereo sample per
// frame through a single-entry hold register and serialises it as standard
// I2S (MSB first, one-bclk delay after the lrclk edge, zero padded slots).
//
// Ports:
//   clk          in  system clock
//   reset        in  synchronous active-high reset
//   enable       in  1 = run serializer; 0 = idle with all stream outputs low
//   s_valid      in  stereo sample present
//   s_ready      out hold register empty
//   s_l_data     in  left sample  (DATA_W, two's complement)
//   s_r_data     in  right sample (DATA_W, two's complement)
//   dac_bclk     out I2S bit clock
//   dac_lrclk    out I2S word select (0 = left, 1 = right)
//   dac_data     out I2S serial data, changes with the falling bclk
//   frame_start  out 1-clk pulse when a frame is loaded into the shifter
//   underrun     out 1-clk pulse when that load found the hold register empty
// ----------------------------------------------------------------------------
module i2s_dac_transmitter
   import i2s_pkg::*;
#(
   parameter int unsigned DATA_W   = I2S_DATA_W,
   parameter int unsigned SLOT_W   = 32,
   parameter int unsigned BCLK_DIV = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_l_data,
   input  logic [DATA_W-1:0] s_r_data,
   output logic              dac_bclk,
   output logic              dac_lrclk,
   output logic              dac_data,
   output logic              frame_start,
   output logic              underrun
);

   localparam int unsigned      FRAME_LEN    = frame_len(SLOT_W);
   localparam int unsigned      CNT_W        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0] BIT_CNT_LAST = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] SLOT_CNT     = CNT_W'(SLOT_W);

   // Frame image as it appears on the wire, MSB first: left sample at the top
   // of the left slot, right sample at the top of the right slot, zero pad.
   // The one-bclk I2S delay comes from emitting the shifter MSB before
   // shifting, so image bit p is on dac_data while bit_cnt is p+1.
   function automatic logic [FRAME_LEN-1:0] frame_image(input stereo_sample_t smp);
      logic [FRAME_LEN-1:0] img;
      img                        = '0;
      img[FRAME_LEN-1 -: DATA_W] = smp.l;
      img[SLOT_W-1    -: DATA_W] = smp.r;
      return img;
   endfunction

   i2s_state_e           state_q, state_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 lrclk_q, lrclk_d;
   logic                 data_q, data_d;
   logic [FRAME_LEN-1:0] shifter_q, shifter_d;
   logic                 frame_start_q, frame_start_d;
   logic                 underrun_q, underrun_d;
   logic                 hold_full_q, hold_full_d;
   stereo_sample_t       hold_q, hold_d;

   logic run;
   logic fall_tick;
   logic bclk_rise_unused;
   logic boundary;
   logic accept;

   // Serializer state: enable alone decides RUN vs IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (enable)  state_d = ST_RUN;
         ST_RUN:  if (!enable) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Gating with enable as well as the state makes a drop of enable clear the
   // stream on the very next edge rather than one cycle later.
   assign run = (state_q == ST_RUN) && enable;

   i2s_bclk_gen #(
      .BCLK_DIV (BCLK_DIV)
   ) u_bclk_gen (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .bclk      (dac_bclk),
      .rise_tick (bclk_rise_unused),
      .fall_tick (fall_tick)
   );

   // bit_cnt starts at its last value so the first falling bclk after RUN is
   // a frame boundary and loads a fresh frame.
   assign boundary = fall_tick && (bit_cnt_q == BIT_CNT_LAST);
   assign s_ready  = !hold_full_q;
   assign accept   = s_valid && s_ready;

   always_comb begin
      bit_cnt_d     = bit_cnt_q;
      lrclk_d       = lrclk_q;
      data_d        = data_q;
      shifter_d     = shifter_q;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;
      hold_full_d   = hold_full_q;
      hold_d        = hold_q;

      if (!run) begin
         bit_cnt_d = BIT_CNT_LAST;
         lrclk_d   = 1'b0;
         data_d    = 1'b0;
         shifter_d = '0;
      end else if (fall_tick) begin
         bit_cnt_d = boundary ? '0 : bit_cnt_q + CNT_W'(1);
         lrclk_d   = (bit_cnt_d >= SLOT_CNT) ? I2S_RIGHT : I2S_LEFT;
         // At the boundary this is the final bit of the old frame's right
         // slot: its LSB when SLOT_W == DATA_W, otherwise pad.
         data_d    = shifter_q[FRAME_LEN-1];
         if (boundary) begin
            frame_start_d = 1'b1;
            if (hold_full_q) begin
               shifter_d   = frame_image(hold_q);
               hold_full_d = 1'b0;
            end else begin
               shifter_d  = '0;
               underrun_d = 1'b1;
            end
         end else begin
            shifter_d = shifter_q << 1;
         end
      end

      // Never collides with the drain above: a boundary only clears a full
      // hold register, and a full register is not ready. A capture on a
      // boundary that found the register empty still reports underrun.
      if (accept) begin
         hold_d.l    = s_l_data;
         hold_d.r    = s_r_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= BIT_CNT_LAST;
         lrclk_q       <= 1'b0;
         data_q        <= 1'b0;
         shifter_q     <= '0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         hold_full_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         lrclk_q       <= lrclk_d;
         data_q        <= data_d;
         shifter_q     <= shifter_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
         hold_full_q   <= hold_full_d;
      end
   end

   // NOTE: the hold data register has no reset; it is only read when
   // hold_full_q is set, so clearing the flag is enough to discard a sample.
   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end

   assign dac_lrclk   = lrclk_q;
   assign dac_data    = data_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;

endmodule
